// File: rtl/video_mode_pkg.sv
// Shared types for the video mode sequencer: mode index, timing record, FSM states
// and the built-in four-entry mode table.
package video_mode_pkg;

    typedef logic [1:0] mode_t;

    typedef struct packed {
        logic [11:0] h_vis;
        logic [11:0] h_fp;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [10:0] v_vis;
        logic [10:0] v_fp;
        logic [10:0] v_sync;
        logic [10:0] v_bp;
    } timing_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_LOAD    = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    localparam int SYNC_DEPTH = 2;

    localparam timing_t MODE_640x480 = '{h_vis: 12'd640, h_fp: 12'd16, h_sync: 12'd96,
        h_bp: 12'd48, v_vis: 11'd480, v_fp: 11'd10, v_sync: 11'd2, v_bp: 11'd33};
    localparam timing_t MODE_800x600 = '{h_vis: 12'd800, h_fp: 12'd40, h_sync: 12'd128,
        h_bp: 12'd88, v_vis: 11'd600, v_fp: 11'd1, v_sync: 11'd4, v_bp: 11'd23};
    localparam timing_t MODE_1280x1024 = '{h_vis: 12'd1280, h_fp: 12'd30, h_sync: 12'd64,
        h_bp: 12'd60, v_vis: 11'd1024, v_fp: 11'd3, v_sync: 11'd5, v_bp: 11'd10};
    localparam timing_t MODE_1920x1080 = '{h_vis: 12'd1920, h_fp: 12'd88, h_sync: 12'd44,
        h_bp: 12'd148, v_vis: 11'd1080, v_fp: 11'd4, v_sync: 11'd5, v_bp: 11'd36};

    // Also used as a constant for the reset value of the registered timing set.
    function automatic timing_t mode_timing(input mode_t m);
        case (m)
            2'd0:    return MODE_640x480;
            2'd1:    return MODE_800x600;
            2'd2:    return MODE_1280x1024;
            default: return MODE_1920x1080;
        endcase
    endfunction

endpackage

// File: rtl/video_mode_rom.sv
// Combinational mode index -> timing set lookup.
module video_mode_rom
    import video_mode_pkg::*;
(
    input  mode_t   idx,
    output timing_t timing
);

    always_comb timing = mode_timing(idx);

endmodule

// File: rtl/video_mode_sequencer.sv
// Mode-change controller for the VGA timing generator: frame-aligned reload, blanking
// until PLL lock plus N frames. Optional button stepping with VIDEO_MODE_BTN_EN.
module video_mode_sequencer
    import video_mode_pkg::*;
#(
    parameter mode_t C_default_mode  = 2'd2,
    parameter int    C_settle_frames = 2,
    parameter int    C_vs_timeout    = 2**22,
    parameter logic  C_vsync_pol     = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        clk_locked,
    input  logic        vga_vsync,
`ifdef VIDEO_MODE_BTN_EN
    input  logic        btn_next,
`endif
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic        mode_rdy,
    output logic        mode_ack,
    output logic [1:0]  mode_cur,
    output logic        force_blank,
    output logic        cfg_load,
    output logic [11:0] cfg_h_vis,
    output logic [11:0] cfg_h_fp,
    output logic [11:0] cfg_h_sync,
    output logic [11:0] cfg_h_bp,
    output logic [10:0] cfg_v_vis,
    output logic [10:0] cfg_v_fp,
    output logic [10:0] cfg_v_sync,
    output logic [10:0] cfg_v_bp,
    output logic        busy
);

    localparam int              TW       = $clog2(C_vs_timeout) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(C_vs_timeout - 1);
    localparam logic [3:0]      SETTLE_N = 4'(C_settle_frames);

    state_t                  state;
    mode_t                   req;
    mode_t                   acc_sel;
    timing_t                 cfg;
    timing_t                 rom_t;
    logic [3:0]              frame_cnt;
    logic [TW-1:0]           tmo_cnt;
    logic                    ack_pend;
    logic [SYNC_DEPTH-1:0]   lk_s;
    logic [SYNC_DEPTH-1:0]   vs_s;
    logic                    locked_sync;
    logic                    vs_edge;
    logic                    btn_req;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            lk_s <= '0;
            vs_s <= {SYNC_DEPTH{~C_vsync_pol}};
        end else begin
            lk_s <= {lk_s[SYNC_DEPTH-2:0], clk_locked};
            vs_s <= {vs_s[SYNC_DEPTH-2:0], vga_vsync};
        end
    end

    assign locked_sync = lk_s[SYNC_DEPTH-1];
    assign vs_edge     = (vs_s[0] == C_vsync_pol) && (vs_s[1] != C_vsync_pol);

`ifdef VIDEO_MODE_BTN_EN
    logic [SYNC_DEPTH-1:0] bt_s;
    logic [15:0]           db_cnt;
    logic                  bt_stable;
    logic                  bt_pend;

    // A press waits until RUN; there it is either taken or dropped in favour of mode_req.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            bt_s      <= '0;
            db_cnt    <= '0;
            bt_stable <= 1'b0;
            bt_pend   <= 1'b0;
        end else begin
            bt_s <= {bt_s[SYNC_DEPTH-2:0], btn_next};
            if (state == ST_RUN) bt_pend <= 1'b0;
            if (bt_s[SYNC_DEPTH-1] == bt_stable) begin
                db_cnt <= '0;
            end else if (&db_cnt) begin
                db_cnt    <= '0;
                bt_stable <= bt_s[SYNC_DEPTH-1];
                if (bt_s[SYNC_DEPTH-1]) bt_pend <= 1'b1;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    assign btn_req = bt_pend;
`else
    assign btn_req = 1'b0;
`endif

    assign acc_sel = mode_req ? mode_t'(mode_sel) : mode_t'(mode_cur + 2'd1);

    video_mode_rom u_rom (
        .idx    (req),
        .timing (rom_t)
    );

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SETTLE;
            mode_cur    <= C_default_mode;
            req         <= C_default_mode;
            cfg         <= mode_timing(C_default_mode);
            force_blank <= 1'b1;
            mode_ack    <= 1'b0;
            cfg_load    <= 1'b0;
            frame_cnt   <= '0;
            tmo_cnt     <= '0;
            ack_pend    <= 1'b0;
        end else begin
            mode_ack <= 1'b0;
            cfg_load <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (mode_req || btn_req) begin
                        req <= acc_sel;
                        if (acc_sel == mode_cur) begin
                            mode_ack <= 1'b1;
                        end else begin
                            state   <= ST_WAIT_VS;
                            tmo_cnt <= '0;
                        end
                    end else if (!locked_sync) begin
                        state       <= ST_SETTLE;
                        force_blank <= 1'b1;
                        frame_cnt   <= '0;
                        ack_pend    <= 1'b0;
                    end
                end
                ST_WAIT_VS: begin
                    // Table output is registered here so cfg_* and cfg_load appear together.
                    if (vs_edge || tmo_cnt == TMO_LAST) begin
                        state       <= ST_LOAD;
                        force_blank <= 1'b1;
                        cfg         <= rom_t;
                        cfg_load    <= 1'b1;
                        mode_cur    <= req;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state     <= ST_SETTLE;
                    frame_cnt <= '0;
                    ack_pend  <= 1'b1;
                end
                default: begin
                    if (!locked_sync) begin
                        frame_cnt <= '0;
                    end else if (vs_edge) begin
                        if (frame_cnt + 4'd1 == SETTLE_N) begin
                            state       <= ST_RUN;
                            force_blank <= 1'b0;
                            mode_ack    <= ack_pend;
                            ack_pend    <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign mode_rdy   = (state == ST_RUN);
    assign busy       = (state != ST_RUN);
    assign cfg_h_vis  = cfg.h_vis;
    assign cfg_h_fp   = cfg.h_fp;
    assign cfg_h_sync = cfg.h_sync;
    assign cfg_h_bp   = cfg.h_bp;
    assign cfg_v_vis  = cfg.v_vis;
    assign cfg_v_fp   = cfg.v_fp;
    assign cfg_v_sync = cfg.v_sync;
    assign cfg_v_bp   = cfg.v_bp;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed bench for video_mode_sequencer: 100-cycle vsync, short vsync timeout.
module tb_video_mode_sequencer;

    logic        clk_pixel = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_locked = 1'b1;
    logic        vga_vsync = 1'b0;
    logic        mode_req = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        mode_rdy, mode_ack, force_blank, cfg_load, busy;
    logic [1:0]  mode_cur;
    logic [11:0] cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [10:0] cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vs_rises = 0;
    int rise_cyc = 0;
    int load_cnt = 0;
    int load_cyc = 0;
    int ack_cnt = 0;
    int acc_cyc = 0;
    bit vs_run = 1'b1;

    video_mode_sequencer #(.C_vs_timeout(300)) dut (
        .clk_pixel  (clk_pixel),
        .rst_n      (rst_n),
        .clk_locked (clk_locked),
        .vga_vsync  (vga_vsync),
`ifdef VIDEO_MODE_BTN_EN
        .btn_next   (1'b0),
`endif
        .mode_req   (mode_req),
        .mode_sel   (mode_sel),
        .mode_rdy   (mode_rdy),
        .mode_ack   (mode_ack),
        .mode_cur   (mode_cur),
        .force_blank(force_blank),
        .cfg_load   (cfg_load),
        .cfg_h_vis  (cfg_h_vis),
        .cfg_h_fp   (cfg_h_fp),
        .cfg_h_sync (cfg_h_sync),
        .cfg_h_bp   (cfg_h_bp),
        .cfg_v_vis  (cfg_v_vis),
        .cfg_v_fp   (cfg_v_fp),
        .cfg_v_sync (cfg_v_sync),
        .cfg_v_bp   (cfg_v_bp),
        .busy       (busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial forever begin
        @(posedge clk_pixel);
        cyc++;
    end

    // Vsync: 100-cycle period, 4 cycles active-high, rising edge at phase 1.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk_pixel);
            #1;
            if (vs_run) begin
                ph = (ph == 99) ? 0 : ph + 1;
                if (ph == 1) begin
                    vs_rises++;
                    rise_cyc = cyc;
                end
                vga_vsync = (ph >= 1 && ph <= 4);
            end else begin
                ph = 0;
                vga_vsync = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk_pixel);
        if (cfg_load === 1'b1) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (mode_ack === 1'b1) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_blank(input logic v, input int max, input string tag);
        int n;
        n = 0;
        while (force_blank !== v && n < max) begin
            @(negedge clk_pixel);
            n++;
        end
        chk(tag, 32'(force_blank), 32'(v));
    endtask

    task automatic wait_load(input int base, input int max, input string tag);
        int n;
        n = 0;
        while (load_cnt == base && n < max) begin
            @(negedge clk_pixel);
            n++;
        end
        chk(tag, load_cnt, base + 1);
    endtask

    task automatic request(input logic [1:0] s);
        @(negedge clk_pixel);
        chk("rdy_before_req", 32'(mode_rdy), 1);
        mode_req = 1'b1;
        mode_sel = s;
        @(posedge clk_pixel);
        #1;
        mode_req = 1'b0;
        acc_cyc = cyc;
    endtask

    initial begin
        int r0, a0, l0;
        bit blank_seen;

        // 1: reset state, post-reset settle
        repeat (20) @(negedge clk_pixel);
        chk("rst_blank", 32'(force_blank), 1);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_rdy", 32'(mode_rdy), 0);
        chk("rst_ack", 32'(mode_ack), 0);
        chk("rst_load", 32'(cfg_load), 0);
        chk("rst_mode", 32'(mode_cur), 2);
        chk("rst_h_vis", 32'(cfg_h_vis), 1280);
        chk("rst_h_fp", 32'(cfg_h_fp), 30);
        chk("rst_h_sync", 32'(cfg_h_sync), 64);
        chk("rst_h_bp", 32'(cfg_h_bp), 60);
        chk("rst_v_vis", 32'(cfg_v_vis), 1024);
        chk("rst_v_bp", 32'(cfg_v_bp), 10);
        r0 = vs_rises;
        a0 = ack_cnt;
        rst_n = 1'b1;
        wait_blank(1'b0, 400, "settle_release_timeout");
        chk("settle_frames", vs_rises - r0, 2);
        chk("settle_no_ack", ack_cnt - a0, 0);
        chk("run_rdy", 32'(mode_rdy), 1);
        chk("run_busy", 32'(busy), 0);

        // 2: switch to mode 0 at a frame boundary
        repeat (10) @(negedge clk_pixel);
        a0 = ack_cnt;
        l0 = load_cnt;
        request(2'd0);
        chk("busy_after_accept", 32'(busy), 1);
        wait_load(l0, 300, "load0_timeout");
        checks++;
        assert (load_cyc - rise_cyc >= 1 && load_cyc - rise_cyc <= 3) else begin
            errors++;
            $error("FAIL load0_latency: observed %0d expected 1..3", load_cyc - rise_cyc);
        end
        chk("load0_h_vis", 32'(cfg_h_vis), 640);
        chk("load0_v_sync", 32'(cfg_v_sync), 2);
        chk("load0_blank", 32'(force_blank), 1);
        chk("load0_mode", 32'(mode_cur), 0);
        r0 = vs_rises;
        wait_blank(1'b0, 400, "mode0_release_timeout");
        chk("mode0_frames", vs_rises - r0, 2);
        chk("mode0_ack", ack_cnt - a0, 1);
        chk("mode0_cur", 32'(mode_cur), 0);

        // 3: request for the current mode acks without a reload
        repeat (10) @(negedge clk_pixel);
        a0 = ack_cnt;
        l0 = load_cnt;
        request(2'd0);
        chk("same_ack_pulse", 32'(mode_ack), 1);
        blank_seen = 1'b0;
        repeat (300) begin
            @(negedge clk_pixel);
            if (force_blank !== 1'b0) blank_seen = 1'b1;
        end
        chk("same_no_blank", 32'(blank_seen), 0);
        chk("same_no_load", load_cnt - l0, 0);
        chk("same_one_ack", ack_cnt - a0, 1);
        chk("same_busy", 32'(busy), 0);

        // 4: lock lost for 3 frames during settle
        a0 = ack_cnt;
        l0 = load_cnt;
        request(2'd3);
        wait_load(l0, 300, "load3_timeout");
        clk_locked = 1'b0;
        repeat (300) @(negedge clk_pixel);
        chk("unlock_blank", 32'(force_blank), 1);
        chk("unlock_busy", 32'(busy), 1);
        clk_locked = 1'b1;
        r0 = vs_rises;
        wait_blank(1'b0, 400, "relock_release_timeout");
        chk("relock_frames", vs_rises - r0, 2);
        chk("mode3_h_vis", 32'(cfg_h_vis), 1920);
        chk("mode3_cur", 32'(mode_cur), 3);
        chk("mode3_ack", ack_cnt - a0, 1);

        // 5: no vsync -> timeout load, settle holds blank
        vs_run = 1'b0;
        repeat (10) @(negedge clk_pixel);
        a0 = ack_cnt;
        l0 = load_cnt;
        request(2'd1);
        wait_load(l0, 400, "tmo_load_timeout");
        chk("tmo_latency", load_cyc - acc_cyc, 300);
        chk("tmo_h_vis", 32'(cfg_h_vis), 800);
        chk("tmo_blank", 32'(force_blank), 1);
        repeat (500) @(negedge clk_pixel);
        chk("tmo_hold_blank", 32'(force_blank), 1);
        chk("tmo_hold_busy", 32'(busy), 1);
        chk("tmo_hold_no_ack", ack_cnt - a0, 0);
        vs_run = 1'b1;
        wait_blank(1'b0, 400, "tmo_release_timeout");
        chk("mode1_cur", 32'(mode_cur), 1);
        chk("mode1_ack", ack_cnt - a0, 1);

        // 6: reset while waiting for vsync
        repeat (5) @(negedge clk_pixel);
        a0 = ack_cnt;
        l0 = load_cnt;
        request(2'd3);
        repeat (10) @(negedge clk_pixel);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_no_load", load_cnt - l0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_blank", 32'(force_blank), 1);
        chk("midrst_busy", 32'(busy), 1);
        chk("midrst_rdy", 32'(mode_rdy), 0);
        chk("midrst_ack", 32'(mode_ack), 0);
        chk("midrst_load", 32'(cfg_load), 0);
        chk("midrst_mode", 32'(mode_cur), 2);
        chk("midrst_h_vis", 32'(cfg_h_vis), 1280);
        repeat (3) @(negedge clk_pixel);
        rst_n = 1'b1;
        wait_blank(1'b0, 400, "midrst_release_timeout");
        chk("midrst_no_ack", ack_cnt - a0, 0);
        chk("midrst_no_load", load_cnt - l0, 0);
        chk("midrst_cur_after", 32'(mode_cur), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_mode_sequencer.md
Name: video_mode_sequencer

Overview:
- Controller for the runtime-programmable VGA timing generator and the VGA-to-DVI chain.
- Accepts mode-change requests from a CPU/ESP32 register or a button, and waits for a frame boundary.
- Forces blank output, loads a new timing set from an internal 4-entry mode table, then holds blank until the pixel PLL is locked and N frames have elapsed.
- Sits between the clock generator and the vga timing instance, in the clk_pixel domain.

Parameters:
- C_default_mode, 2, mode index loaded at reset (0:640x480 1:800x600 2:1280x1024 3:1920x1080).
- C_settle_frames, 2, vsync edges counted with clk_locked high before blank is released (1..15).
- C_vs_timeout, 2**22, clk_pixel cycles to wait for a vsync edge before loading anyway.
- C_vsync_pol, 1'b1, active level of vga_vsync; the leading edge is the edge into this level.

Ports:
- clk_pixel  in  1  pixel clock; all logic is in this domain.
- rst_n  in  1  asynchronous active-low reset.
- clk_locked  in  1  PLL lock; treated as asynchronous, synchronised with 2 flops.
- vga_vsync  in  1  vsync from the timing generator.
- mode_req  in  1  request valid.
- mode_sel  in  2  requested mode; sampled when mode_req && mode_rdy.
- mode_rdy  out  1  high only in RUN.
- mode_ack  out  1  one-cycle pulse when a request completes.
- mode_cur  out  2  currently loaded mode.
- force_blank  out  1  forces vga_blank/black into vga2dvid.
- cfg_load  out  1  one-cycle strobe; the timing generator restarts at (0,0) with the cfg_* values.
- cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp  out  12 each  horizontal timing.
- cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp  out  11 each  vertical timing.
- busy  out  1  state != RUN.

Behaviour:
- Reset values:
  - state = SETTLE, mode_cur = C_default_mode, cfg_* = table[C_default_mode].
  - force_blank = 1, busy = 1, mode_rdy = 0, mode_ack = 0, cfg_load = 0.
  - Frame count = 0, timeout count = 0.
- Mode table (vis/fp/sync/bp):
  - 0: 640/16/96/48, 480/10/2/33.
  - 1: 800/40/128/88, 600/1/4/23.
  - 2: 1280/30/64/60, 1024/3/5/10.
  - 3: 1920/88/44/148, 1080/4/5/36.
- vs_edge: one-cycle pulse on the registered leading edge of vga_vsync (2 flops plus compare; latency 2 cycles).
- States:
  - RUN: mode_rdy = 1. On accept, latch req = mode_sel.
    - If req == mode_cur: pulse mode_ack next cycle and stay in RUN (no blank, no load).
    - Otherwise go to WAIT_VS.
  - WAIT_VS: timeout counter runs. On vs_edge, or when the count reaches C_vs_timeout-1, go to LOAD.
  - LOAD: exactly 1 cycle.
    - force_blank = 1.
    - cfg_* = table[req] registered so the values are valid in the same cycle as cfg_load = 1.
    - mode_cur = req.
    - Go to SETTLE with frame count = 0.
  - SETTLE: force_blank = 1.
    - Each vs_edge while locked_sync = 1 increments the frame count.
    - locked_sync = 0 clears the count.
    - When the count reaches C_settle_frames: force_blank <= 0, mode_ack pulses (suppressed for the post-reset settle), go to RUN.
- force_blank asserts on the WAIT_VS -> LOAD transition and is never low during LOAD or SETTLE.
- A request arriving while busy is not accepted (mode_rdy = 0); the requester holds mode_req.
- If clk_locked drops in RUN: go to SETTLE with force_blank = 1, no ack, and mode_cur unchanged.
- Reset mid-operation restores the reset state; a pending request is discarded without ack.
- No vsync at all: the timeout path is taken once in WAIT_VS; SETTLE then waits indefinitely, and busy stays 1.

Optional Feature:
- VIDEO_MODE_BTN_EN defined:
  - Adds input btn_next (1 bit, asynchronous), synchronised and debounced with a 2**16-cycle stable counter.
  - A debounced rising edge raises an internal request for mode_cur+1 (wraps 3 -> 0).
  - The internal request is accepted only in RUN.
  - When it coincides with mode_req, the external request wins and the button press is dropped.
- Not defined: the port is absent and no debounce logic is built.

Decomposition:
- video_mode_pkg:
  - typedef mode index (2 bits).
  - struct/record timing_t with 8 fields.
  - localparams for the four table rows, state encodings, and synchroniser depth 2.
- Sub-module video_mode_rom: combinational index -> timing_t lookup.
- The sequencer registers the lookup output at LOAD.

Test Plan:
1. Reset with clk_locked = 1 and vsync period 100 cycles → cfg = mode 2 (1280/30/64/60…), force_blank falls after 2 vs_edges, no mode_ack.
2. mode_req with mode_sel = 0 in RUN → busy next cycle; cfg_load pulse within 2 cycles of the next vs_edge with cfg_h_vis = 640; force_blank low and mode_ack after 2 further frames; mode_cur = 0.
3. mode_req with mode_sel = mode_cur → mode_ack one cycle later, and force_blank and cfg_load never assert.
4. clk_locked dropped for 3 frames during SETTLE → frame count resets; release occurs 2 frames after lock returns.
5. vsync held constant after the request → cfg_load exactly C_vs_timeout cycles after accept; SETTLE holds blank.
6. rst_n asserted during WAIT_VS → outputs immediately return to reset values; no mode_ack; mode_cur = 2.
